axonerve_kvs_axi_mem_responder: RTL and testbench



---
 rtl/axonerve_kvs_axi_mem_pkg.sv | 22 ++
 rtl/axonerve_kvs_sdp_bram.sv | 36 +++
 rtl/axonerve_kvs_axi_mem_responder.sv | 161 ++++++++++++++++
 tb/tb_axonerve_kvs_axi_mem_responder.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axonerve_kvs_axi_mem_pkg.sv
// Shared types and default geometry for the AXI4 memory responder.
package axonerve_kvs_axi_mem_pkg;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_DATA,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

  localparam int LP_ADDR_W   = 64;
  localparam int LP_DATA_W   = 512;
  localparam int LP_DEPTH    = 1024;
  localparam int LP_STRB_W   = LP_DATA_W / 8;
  localparam int LP_IDX_W    = $clog2(LP_DEPTH);
  localparam int LP_BYTE_LSB = $clog2(LP_STRB_W);

endpackage

// File: rtl/axonerve_kvs_sdp_bram.sv
// Simple dual-port RAM: byte-enabled write port, read-first registered read port.
module axonerve_kvs_sdp_bram #(
  parameter int DATA_W = 512,
  parameter int DEPTH  = 1024
) (
  input  logic                       clk,
  input  logic                       rst_i,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr_i,
  input  logic [DATA_W/8-1:0]        wr_be_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  input  logic                       rd_en_i,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr_i,
  output logic [DATA_W-1:0]          rd_data_o
);

  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // NOTE: the array has no reset so it maps onto block RAM; only the output register is reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < STRB_W; b++) begin
      if (wr_be_i[b]) mem_q[wr_addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
    end
  end

  // NOTE: non-blocking writes above mean a same-edge read here sees the old word (read-first).
  always_ff @(posedge clk) begin
    if (rst_i)        rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axonerve_kvs_axi_mem_responder.sv
// AXI4 slave memory: INCR full-width bursts against an on-chip byte-writable RAM.
module axonerve_kvs_axi_mem_responder
  import axonerve_kvs_axi_mem_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = LP_ADDR_W,
  parameter int C_S_AXI_DATA_WIDTH = LP_DATA_W,
  parameter int C_MEM_DEPTH        = LP_DEPTH
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                      s_axi_awlen,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                      s_axi_arlen,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                            s_axi_rlast,
  output logic                            protocol_err
);

  localparam int STRB_W   = C_S_AXI_DATA_WIDTH / 8;
  localparam int IDX_W    = $clog2(C_MEM_DEPTH);
  localparam int BYTE_LSB = $clog2(STRB_W);
  typedef logic [IDX_W-1:0] idx_t;

  wr_state_t wr_state_q, wr_state_d;
  idx_t      wr_idx_q, wr_idx_d;
  logic [7:0] wr_len_q, wr_len_d, wr_cnt_q, wr_cnt_d;
  logic      perr_q, perr_d;

  rd_state_t rd_state_q, rd_state_d;
  idx_t      rd_idx_q, rd_idx_d;
  logic [7:0] rd_len_q, rd_len_d, rd_cnt_q, rd_cnt_d;

  logic [STRB_W-1:0]             ram_we;
  logic                          ram_re;
  idx_t                          ram_raddr;
  logic [C_S_AXI_DATA_WIDTH-1:0] ram_rdata;
  logic                          wr_last;
  logic                          unused_addr_bits;

  // Handshake outputs are forced low while areset is held, not just after the edge.
  assign s_axi_awready = (wr_state_q == WR_IDLE) && !areset;
  assign s_axi_wready  = (wr_state_q == WR_DATA) && !areset;
  assign s_axi_bvalid  = (wr_state_q == WR_RESP) && !areset;
  assign s_axi_arready = (rd_state_q == RD_IDLE) && !areset;
  assign s_axi_rvalid  = (rd_state_q == RD_DATA) && !areset;
  assign s_axi_rlast   = s_axi_rvalid && (rd_cnt_q == rd_len_q);
  assign s_axi_rdata   = areset ? '0 : ram_rdata;
  assign protocol_err  = perr_q && !areset;
  assign wr_last       = (wr_cnt_q == wr_len_q);
  assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

  always_comb begin
    wr_state_d = wr_state_q;
    wr_idx_d   = wr_idx_q;
    wr_len_d   = wr_len_q;
    wr_cnt_d   = wr_cnt_q;
    perr_d     = perr_q;
    ram_we     = '0;
    unique case (wr_state_q)
      WR_IDLE: if (s_axi_awvalid && s_axi_awready) begin
        wr_idx_d   = s_axi_awaddr[BYTE_LSB +: IDX_W];
        wr_len_d   = s_axi_awlen;
        wr_cnt_d   = 8'd0;
        wr_state_d = WR_DATA;
      end
      WR_DATA: if (s_axi_wvalid && s_axi_wready) begin
        ram_we   = s_axi_wstrb;
        wr_idx_d = wr_idx_q + idx_t'(1);
        wr_cnt_d = wr_cnt_q + 8'd1;
        // The beat count, not wlast, terminates the burst.
        if (s_axi_wlast != wr_last) perr_d = 1'b1;
        if (wr_last) wr_state_d = WR_RESP;
      end
      WR_RESP: if (s_axi_bready && s_axi_bvalid) wr_state_d = WR_IDLE;
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_idx_d   = rd_idx_q;
    rd_len_d   = rd_len_q;
    rd_cnt_d   = rd_cnt_q;
    ram_re     = 1'b0;
    ram_raddr  = rd_idx_q;
    unique case (rd_state_q)
      RD_IDLE: if (s_axi_arvalid && s_axi_arready) begin
        rd_idx_d   = s_axi_araddr[BYTE_LSB +: IDX_W];
        rd_len_d   = s_axi_arlen;
        rd_cnt_d   = 8'd0;
        ram_re     = 1'b1;
        ram_raddr  = rd_idx_d;
        rd_state_d = RD_DATA;
      end
      RD_DATA: if (s_axi_rvalid && s_axi_rready) begin
        if (s_axi_rlast) begin
          rd_state_d = RD_IDLE;
        end else begin
          rd_idx_d  = rd_idx_q + idx_t'(1);
          rd_cnt_d  = rd_cnt_q + 8'd1;
          ram_re    = 1'b1;
          ram_raddr = rd_idx_d;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state_q <= WR_IDLE;
      wr_idx_q   <= '0;
      wr_len_q   <= '0;
      wr_cnt_q   <= '0;
      perr_q     <= 1'b0;
      rd_state_q <= RD_IDLE;
      rd_idx_q   <= '0;
      rd_len_q   <= '0;
      rd_cnt_q   <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_idx_q   <= wr_idx_d;
      wr_len_q   <= wr_len_d;
      wr_cnt_q   <= wr_cnt_d;
      perr_q     <= perr_d;
      rd_state_q <= rd_state_d;
      rd_idx_q   <= rd_idx_d;
      rd_len_q   <= rd_len_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

  axonerve_kvs_sdp_bram #(
    .DATA_W (C_S_AXI_DATA_WIDTH),
    .DEPTH  (C_MEM_DEPTH)
  ) u_ram (
    .clk       (aclk),
    .rst_i     (areset),
    .wr_addr_i (wr_idx_q),
    .wr_be_i   (ram_we),
    .wr_data_i (s_axi_wdata),
    .rd_en_i   (ram_re),
    .rd_addr_i (ram_raddr),
    .rd_data_o (ram_rdata)
  );

endmodule

// File: tb/tb_axonerve_kvs_axi_mem_responder.sv
// Directed bench for the AXI4 memory responder: vector table plus multi-cycle sequences.
module tb_axonerve_kvs_axi_mem_responder;

  localparam int DW = 512;
  localparam int AW = 64;
  localparam int SW = DW / 8;
  typedef logic [DW-1:0] beat_t;
  typedef logic [SW-1:0] strb_t;

  logic          aclk = 1'b0;
  logic          areset;
  logic          s_axi_awvalid, s_axi_awready;
  logic [AW-1:0] s_axi_awaddr;
  logic [7:0]    s_axi_awlen;
  logic          s_axi_wvalid, s_axi_wready;
  beat_t         s_axi_wdata;
  strb_t         s_axi_wstrb;
  logic          s_axi_wlast;
  logic          s_axi_bvalid, s_axi_bready;
  logic          s_axi_arvalid, s_axi_arready;
  logic [AW-1:0] s_axi_araddr;
  logic [7:0]    s_axi_arlen;
  logic          s_axi_rvalid, s_axi_rready;
  beat_t         s_axi_rdata;
  logic          s_axi_rlast;
  logic          protocol_err;

  axonerve_kvs_axi_mem_responder dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awlen   (s_axi_awlen),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wlast   (s_axi_wlast),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arlen   (s_axi_arlen),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rlast   (s_axi_rlast),
    .protocol_err  (protocol_err)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [AW-1:0] addr;
    beat_t         wdata;
    strb_t         wstrb;
    beat_t         exp;
  } vec_t;

  vec_t  vecs[6];
  beat_t wbuf[256];
  beat_t rexp[256];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic check(input string name, input beat_t act, input beat_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: no handshake within bound", name);
  endtask

  task automatic do_aw(input logic [AW-1:0] addr, input logic [7:0] len);
    int n = 0;
    @(negedge aclk);
    s_axi_awvalid = 1'b1; s_axi_awaddr = addr; s_axi_awlen = len;
    while (!s_axi_awready && n < 100) begin @(negedge aclk); n++; end
    if (n >= 100) timeout_fail("aw_wait");
    @(posedge aclk); #1;
    s_axi_awvalid = 1'b0;
  endtask

  task automatic do_ar(input logic [AW-1:0] addr, input logic [7:0] len);
    int n = 0;
    @(negedge aclk);
    s_axi_arvalid = 1'b1; s_axi_araddr = addr; s_axi_arlen = len;
    while (!s_axi_arready && n < 100) begin @(negedge aclk); n++; end
    if (n >= 100) timeout_fail("ar_wait");
    @(posedge aclk); #1;
    s_axi_arvalid = 1'b0;
  endtask

  // Writes wbuf[0..len]; wlast is driven on beat wlast_beat (len for a well-formed burst).
  task automatic write_burst(input logic [AW-1:0] addr, input int len, input strb_t strb,
                             input int wlast_beat);
    int n;
    do_aw(addr, 8'(len));
    for (int i = 0; i <= len; i++) begin
      @(negedge aclk);
      if (i > 0) check($sformatf("bvalid_early_b%0d", i), beat_t'(s_axi_bvalid), '0);
      s_axi_wvalid = 1'b1; s_axi_wdata = wbuf[i]; s_axi_wstrb = strb;
      s_axi_wlast = (i == wlast_beat);
      n = 0;
      while (!s_axi_wready && n < 100) begin @(negedge aclk); n++; end
      if (n >= 100) timeout_fail("w_wait");
      @(posedge aclk); #1;
      s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    end
    @(negedge aclk);
    check("bvalid_after_last_w", beat_t'(s_axi_bvalid), beat_t'(1'b1));
    s_axi_bready = 1'b1;
    @(posedge aclk); #1;
    s_axi_bready = 1'b0;
    @(negedge aclk);
    check("awready_after_b", beat_t'(s_axi_awready), beat_t'(1'b1));
    check("bvalid_drop_after_b", beat_t'(s_axi_bvalid), '0);
  endtask

  // Reads len+1 beats against rexp[]; rready follows pat[k%4] each cycle.
  task automatic read_burst(input logic [AW-1:0] addr, input int len, input logic [3:0] pat);
    int beat = 0;
    int cyc  = 0;
    do_ar(addr, 8'(len));
    while (beat <= len && cyc < 2000) begin
      @(negedge aclk);
      check($sformatf("rvalid_b%0d", beat), beat_t'(s_axi_rvalid), beat_t'(1'b1));
      check($sformatf("rdata_b%0d", beat), s_axi_rdata, rexp[beat]);
      check($sformatf("rlast_b%0d", beat), beat_t'(s_axi_rlast), beat_t'(beat == len));
      s_axi_rready = pat[cyc % 4];
      @(posedge aclk); #1;
      if (s_axi_rready) beat++;
      s_axi_rready = 1'b0;
      cyc++;
    end
    if (beat <= len) timeout_fail("r_burst");
    @(negedge aclk);
    check("rvalid_drop_after_rlast", beat_t'(s_axi_rvalid), '0);
    check("arready_after_rlast", beat_t'(s_axi_arready), beat_t'(1'b1));
  endtask

  task automatic read_single(input logic [AW-1:0] addr, input beat_t exp);
    rexp[0] = exp;
    read_burst(addr, 0, 4'b1111);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t old_val, keep;
    areset = 1'b1;
    s_axi_awvalid = 0; s_axi_awaddr = '0; s_axi_awlen = '0;
    s_axi_wvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 0;
    s_axi_bready = 0; s_axi_arvalid = 0; s_axi_araddr = '0; s_axi_arlen = '0;
    s_axi_rready = 0;

    vecs[0] = '{64'h40, {64{8'hA5}}, {SW{1'b1}}, {64{8'hA5}}};
    vecs[1] = '{64'h80, {64{8'hFF}}, {SW{1'b1}}, {64{8'hFF}}};
    vecs[2] = '{64'h80, {64{8'h11}}, strb_t'(64'hF), {{60{8'hFF}}, {4{8'h11}}}};
    vecs[3] = '{64'hC3, {64{8'h5A}}, {SW{1'b1}}, {64{8'h5A}}};
    vecs[4] = '{64'h7F, {64{8'h00}}, strb_t'(0), {64{8'hA5}}};
    vecs[5] = '{64'hC0, {64{8'h33}}, strb_t'(64'hFF00_0000_0000_0000), {{8{8'h33}}, {56{8'h5A}}}};

    repeat (3) @(negedge aclk);
    check("rst_awready", beat_t'(s_axi_awready), '0);
    check("rst_arready", beat_t'(s_axi_arready), '0);
    check("rst_wready", beat_t'(s_axi_wready), '0);
    check("rst_bvalid", beat_t'(s_axi_bvalid), '0);
    check("rst_rvalid", beat_t'(s_axi_rvalid), '0);
    check("rst_rlast", beat_t'(s_axi_rlast), '0);
    check("rst_rdata", s_axi_rdata, '0);
    check("rst_perr", beat_t'(protocol_err), '0);
    areset = 1'b0;
    @(negedge aclk);
    check("post_rst_awready", beat_t'(s_axi_awready), beat_t'(1'b1));
    check("post_rst_arready", beat_t'(s_axi_arready), beat_t'(1'b1));

    // Single-beat vectors: full write, partial strobes, ignored low address bits.
    for (int v = 0; v < 6; v++) begin
      wbuf[0] = vecs[v].wdata;
      write_burst(vecs[v].addr, 0, vecs[v].wstrb, 0);
      read_single(vecs[v].addr, vecs[v].exp);
    end

    // 16-beat burst, read back with rready 1,0,0,1.
    for (int i = 0; i < 16; i++) begin
      wbuf[i] = {16{32'h1000_0000 + 32'(i)}};
      rexp[i] = wbuf[i];
    end
    write_burst(64'h1000, 15, {SW{1'b1}}, 15);
    read_burst(64'h1000, 15, 4'b1001);

    // Wrap from beat 1022 through 0 and 1.
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = {16{32'hC000_0000 + 32'(i)}};
      rexp[i] = wbuf[i];
    end
    write_burst(64'hFF80, 3, {SW{1'b1}}, 3);
    read_burst(64'hFF80, 3, 4'b1111);
    read_single(64'h0, {16{32'hC000_0002}});
    read_single(64'h40, {16{32'hC000_0003}});

    // Early wlast: error flagged, burst still runs 4 beats.
    check("perr_before", beat_t'(protocol_err), '0);
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = {16{32'hE000_0000 + 32'(i)}};
      rexp[i] = wbuf[i];
    end
    write_burst(64'h2000, 3, {SW{1'b1}}, 2);
    check("perr_set", beat_t'(protocol_err), beat_t'(1'b1));
    read_burst(64'h2000, 3, 4'b1111);
    wbuf[0] = {64{8'h44}};
    write_burst(64'h3000, 0, {SW{1'b1}}, 0);
    check("perr_sticky", beat_t'(protocol_err), beat_t'(1'b1));

    // Same-index read and write accepted on the same edge: read sees old data.
    old_val = {16{32'hC000_0003}};
    do_aw(64'h40, 8'd0);
    @(negedge aclk);
    s_axi_wvalid = 1'b1; s_axi_wdata = {64{8'h77}}; s_axi_wstrb = {SW{1'b1}}; s_axi_wlast = 1'b1;
    s_axi_arvalid = 1'b1; s_axi_araddr = 64'h40; s_axi_arlen = 8'd0;
    check("conc_wready", beat_t'(s_axi_wready), beat_t'(1'b1));
    check("conc_arready", beat_t'(s_axi_arready), beat_t'(1'b1));
    @(posedge aclk); #1;
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_arvalid = 1'b0;
    @(negedge aclk);
    check("conc_rvalid", beat_t'(s_axi_rvalid), beat_t'(1'b1));
    check("conc_rdata_old", s_axi_rdata, old_val);
    check("conc_bvalid", beat_t'(s_axi_bvalid), beat_t'(1'b1));
    s_axi_rready = 1'b1; s_axi_bready = 1'b1;
    @(posedge aclk); #1;
    s_axi_rready = 1'b0; s_axi_bready = 1'b0;
    read_single(64'h40, {64{8'h77}});

    // Reset while beat 5 of a 16-beat read is presented.
    for (int i = 0; i < 16; i++) rexp[i] = {16{32'h1000_0000 + 32'(i)}};
    do_ar(64'h1000, 8'd15);
    for (int b = 0; b < 5; b++) begin
      @(negedge aclk);
      check($sformatf("abort_rdata_b%0d", b), s_axi_rdata, rexp[b]);
      s_axi_rready = 1'b1;
      @(posedge aclk); #1;
      s_axi_rready = 1'b0;
    end
    @(negedge aclk);
    check("abort_rdata_b5", s_axi_rdata, rexp[5]);
    areset = 1'b1;
    @(negedge aclk);
    check("abort_rvalid", beat_t'(s_axi_rvalid), '0);
    check("abort_arready_in_rst", beat_t'(s_axi_arready), '0);
    areset = 1'b0;
    @(negedge aclk);
    check("abort_arready", beat_t'(s_axi_arready), beat_t'(1'b1));
    check("abort_rvalid_idle", beat_t'(s_axi_rvalid), '0);
    check("perr_cleared", beat_t'(protocol_err), '0);
    keep = rexp[5];
    read_single(64'h1140, keep);
    for (int i = 0; i < 16; i++) rexp[i] = {16{32'h1000_0000 + 32'(i)}};
    read_burst(64'h1000, 15, 4'b1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
